// File: rtl/frame_packer_param.sv
// frame_packer_param: parametrised single-clock frame packer.
// Takes DATA_W-bit words from a valid/ready stream and emits MSB-first serial
// frames {SYNC(8), CNT(8), DATA(DATA_W), CRC(8)} towards the line encoder.
// Build option: define FRAME_PACKER_CRC_EN to append the bit-serial CRC-8 byte
// (poly 0x07, init 0x00, over CNT and DATA). Without it the frame ends after DATA.
//
// Handshake rules, both sides: a transfer happens on a clk_sys rising edge
// where valid && ready are both high. s_ready is high only in IDLE. tx_valid
// and tx_bit are registered and are held unchanged until tx_ready takes the bit.
module frame_packer_param #(
  parameter int         DATA_W    = 32,
  parameter logic [7:0] SYNC_BYTE = 8'hAA,
  parameter int         GAP_BITS  = 0
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              cnt_clr,
  output logic              tx_bit,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [7:0]        frame_count,
  output logic              busy,
  output logic [1:0]        state_dbg
);

`ifdef FRAME_PACKER_CRC_EN
  localparam int CRC_W = 8;
`else
  localparam int CRC_W = 0;
`endif
  // SYNC + CNT + DATA live in the shift register; the CRC byte is sent from its own register
  localparam int HDR_DATA_W = 16 + DATA_W;
  localparam int FRAME_W    = HDR_DATA_W + CRC_W;
  localparam int BC_W       = $clog2(FRAME_W);

  localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(FRAME_W - 1);
  localparam logic [BC_W-1:0] BC_ONE    = BC_W'(1);
  localparam logic [7:0]      GAP_LAST  = 8'(GAP_BITS > 0 ? GAP_BITS - 1 : 0);
`ifdef FRAME_PACKER_CRC_EN
  localparam logic [BC_W-1:0] FIRST_CNT = BC_W'(8);
  localparam logic [BC_W-1:0] LAST_DATA = BC_W'(HDR_DATA_W - 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t                state;
  logic [HDR_DATA_W-1:0] shift_q;
  logic [HDR_DATA_W-1:0] shift_nx;
  logic [BC_W-1:0]       bitcnt;
  logic [7:0]            cnt;
  logic [7:0]            gap_cnt;
  logic                  xfer;
  logic                  next_bit;
`ifdef FRAME_PACKER_CRC_EN
  logic [7:0]            crc_q;
  logic [7:0]            crc_nx;
  logic                  fb;
`endif

  assign xfer        = (state == ST_SEND) && tx_valid && tx_ready;
  assign shift_nx    = {shift_q[HDR_DATA_W-2:0], 1'b0};
  assign frame_count = cnt;
  assign state_dbg   = state;

`ifdef FRAME_PACKER_CRC_EN
  // CRC update for the bit leaving now, and choice of the bit that follows it
  always_comb begin
    crc_nx   = crc_q;
    fb       = crc_q[7] ^ shift_q[HDR_DATA_W-1];
    next_bit = shift_nx[HDR_DATA_W-1];
    if (bitcnt >= FIRST_CNT && bitcnt <= LAST_DATA) begin
      crc_nx = {crc_q[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end else if (bitcnt > LAST_DATA) begin
      // CRC phase: the register itself is the shifter for the trailing byte
      crc_nx = {crc_q[6:0], 1'b0};
    end
    if (bitcnt >= LAST_DATA) begin
      next_bit = crc_nx[7];
    end
  end
`else
  // Without CRC every bit comes straight out of the shift register
  always_comb begin
    next_bit = shift_nx[HDR_DATA_W-1];
  end
`endif

  // Frame counter, FSM and registered stream outputs
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      s_ready  <= 1'b1;
      tx_valid <= 1'b0;
      tx_bit   <= 1'b0;
      busy     <= 1'b0;
      cnt      <= 8'd0;
      shift_q  <= '0;
      bitcnt   <= '0;
      gap_cnt  <= 8'd0;
`ifdef FRAME_PACKER_CRC_EN
      crc_q    <= 8'd0;
`endif
    end else begin
      // clear beats increment; an accepted frame still carries the old value
      if (cnt_clr) begin
        cnt <= 8'd0;
      end else if (state == ST_IDLE && s_valid && s_ready) begin
        cnt <= cnt + 8'd1;
      end

      case (state)
        ST_IDLE: begin
          if (s_valid && s_ready) begin
            shift_q  <= {SYNC_BYTE, cnt, s_data};
            bitcnt   <= '0;
            tx_valid <= 1'b1;
            tx_bit   <= SYNC_BYTE[7];
            s_ready  <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_SEND;
`ifdef FRAME_PACKER_CRC_EN
            crc_q    <= 8'd0;
`endif
          end
        end
        ST_SEND: begin
          if (xfer) begin
            shift_q <= shift_nx;
            bitcnt  <= bitcnt + BC_ONE;
`ifdef FRAME_PACKER_CRC_EN
            crc_q   <= crc_nx;
`endif
            if (bitcnt == LAST_BIT) begin
              tx_valid <= 1'b0;
              tx_bit   <= 1'b0;
              if (GAP_BITS > 0) begin
                gap_cnt <= 8'd0;
                state   <= ST_GAP;
              end else begin
                s_ready <= 1'b1;
                busy    <= 1'b0;
                state   <= ST_IDLE;
              end
            end else begin
              tx_bit <= next_bit;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            s_ready <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: begin
          tx_valid <= 1'b0;
          tx_bit   <= 1'b0;
          s_ready  <= 1'b1;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
